// File: rtl/ascon_pkg.sv
// Shared ASCON types and constants for the permutation engine and its round datapath.
package ascon_pkg;

    localparam int NB_ROUNDS_MAX = 12;

    // Word 0 is x0 ... word 4 is x4.
    typedef logic [4:0][63:0] t_state_array;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } t_perm_fsm;

    // Index 0 is the first constant of p12; p^N starts at NB_ROUNDS_MAX - N.
    localparam logic [0:NB_ROUNDS_MAX-1][7:0] ROUND_CONSTANTS = {
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/permutation_ctrl_if.sv
// Request/response bundle between the mode FSM (master) and permutation_ctrl (slave).
interface permutation_ctrl_if;
    import ascon_pkg::*;

    logic         i_start;
    logic [3:0]   i_num_rounds;
    t_state_array i_state;
    logic         o_ready;
    logic         o_valid;
    t_state_array o_state;

    modport master (
        output i_start, i_num_rounds, i_state,
        input  o_ready, o_valid, o_state
    );

    modport slave (
        input  i_start, i_num_rounds, i_state,
        output o_ready, o_valid, o_state
    );

endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bit-sliced S-box, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [3:0]   i_round,
    input  t_state_array i_state,
    output t_state_array o_state
);

    t_state_array c_state;
    t_state_array s_state;
    logic [63:0]  x0, x1, x2, x3, x4;
    logic [63:0]  t0, t1, t2, t3, t4;
    logic [63:0]  y0, y1, y2, y3, y4;

    always_comb begin
        c_state    = i_state;
        c_state[2] = i_state[2] ^ {56'h0, ROUND_CONSTANTS[i_round]};
    end

    // S-box applied on all 64 five-bit columns at once.
    always_comb begin
        x0 = c_state[0] ^ c_state[4];
        x1 = c_state[1];
        x2 = c_state[2] ^ c_state[1];
        x3 = c_state[3];
        x4 = c_state[4] ^ c_state[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        y0 = x0 ^ t1;
        y1 = x1 ^ t2;
        y2 = x2 ^ t3;
        y3 = x3 ^ t4;
        y4 = x4 ^ t0;
        s_state[0] = y0 ^ y4;
        s_state[1] = y1 ^ y0;
        s_state[2] = ~y2;
        s_state[3] = y3 ^ y2;
        s_state[4] = y4;
    end

    always_comb begin
        o_state[0] = s_state[0] ^ ror64(s_state[0], 19) ^ ror64(s_state[0], 28);
        o_state[1] = s_state[1] ^ ror64(s_state[1], 61) ^ ror64(s_state[1], 39);
        o_state[2] = s_state[2] ^ ror64(s_state[2],  1) ^ ror64(s_state[2],  6);
        o_state[3] = s_state[3] ^ ror64(s_state[3], 10) ^ ror64(s_state[3], 17);
        o_state[4] = s_state[4] ^ ror64(s_state[4],  7) ^ ror64(s_state[4], 41);
    end

endmodule

// File: rtl/permutation_ctrl.sv
// Iterative ASCON p^N engine (N = 1..12). Define PERM_UNROLL2_EN to apply two rounds per cycle.
module permutation_ctrl
    import ascon_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    permutation_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

    t_perm_fsm    fsm_q, fsm_d;
    t_state_array state_q, state_d;
    logic [3:0]   round_q, round_d;
    t_state_array rnd0_out;
    logic         start_ok;

    ascon_round u_round0 (
        .i_round (round_q),
        .i_state (state_q),
        .o_state (rnd0_out)
    );

`ifdef PERM_UNROLL2_EN
    logic [3:0]   round1;
    t_state_array rnd1_out;

    // Held at the last index when only one round is left; its output is unused then.
    assign round1 = (round_q >= LAST_ROUND) ? LAST_ROUND : round_q + 4'd1;

    ascon_round u_round1 (
        .i_round (round1),
        .i_state (rnd0_out),
        .o_state (rnd1_out)
    );
`endif

    assign start_ok = bus.i_start && (bus.i_num_rounds != 4'd0)
                    && (bus.i_num_rounds <= 4'(NB_ROUNDS_MAX));

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = bus.i_state;
                    round_d = 4'(NB_ROUNDS_MAX) - bus.i_num_rounds;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
`ifdef PERM_UNROLL2_EN
                if (round_q >= LAST_ROUND) begin
                    state_d = rnd0_out;
                    fsm_d   = DONE;
                end else begin
                    state_d = rnd1_out;
                    round_d = (round1 == LAST_ROUND) ? LAST_ROUND : round_q + 4'd2;
                    if (round1 == LAST_ROUND) fsm_d = DONE;
                end
`else
                state_d = rnd0_out;
                if (round_q >= LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
`endif
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign bus.o_ready = (fsm_q == IDLE);
    assign bus.o_valid = (fsm_q == DONE);
    assign bus.o_state = state_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl against a table-driven ASCON reference model.
module tb_permutation_ctrl;
    import ascon_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    permutation_ctrl_if bus ();

    permutation_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT_A [0:4] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [0:4] = '{28, 39, 6, 17, 41};

    typedef struct {
        t_state_array st;
        int           due;
        int           n;
    } exp_t;

    exp_t         sb[$];
    t_state_array last_res;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[(i + k) % 64];
        return y;
    endfunction

    function automatic t_state_array model_perm(input t_state_array s, input int n);
        t_state_array x;
        logic [4:0]   v;
        logic [4:0]   o;
        x = s;
        for (int r = 12 - n; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(240 - 15 * r);
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = SBOX[v];
                {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]} = o;
            end
            for (int w = 0; w < 5; w++)
                x[w] = x[w] ^ rotr(x[w], ROT_A[w]) ^ rotr(x[w], ROT_B[w]);
        end
        return x;
    endfunction

    function automatic int latency(input int n);
`ifdef PERM_UNROLL2_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    function automatic t_state_array rand_state();
        t_state_array s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    // Result monitor: every o_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.o_state !== e.st || cyc != e.due) begin
                    errors++;
                    $display("FAIL result N=%0d: got cycle %0d state %h, want cycle %0d state %h",
                             e.n, cyc, bus.o_state, e.due, e.st);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check_state(input string name, input t_state_array got, input t_state_array want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge where o_ready is high again.
    task automatic do_perm(input int n, input t_state_array s, input bit push, input bit noise);
        int g;
        g = 0;
        while (bus.o_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout before N=%0d", n);
        end
        bus.i_start      = 1'b1;
        bus.i_num_rounds = 4'(n);
        bus.i_state      = s;
        if (push) begin
            sb.push_back('{st: model_perm(s, n), due: cyc + latency(n), n: n});
            last_res = model_perm(s, n);
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_state = rand_state();
        g = 0;
        while (bus.o_ready !== 1'b1 && g < 100) begin
            if (noise) begin
                bus.i_start      = 1'($urandom_range(0, 1));
                bus.i_num_rounds = 4'($urandom_range(1, 12));
                bus.i_state      = rand_state();
            end
            @(negedge clk);
            g++;
        end
        bus.i_start = 1'b0;
    endtask

    initial begin
        t_state_array init_st, pat, zero_st;
        int g;
        zero_st          = '0;
        last_res         = '0;
        bus.i_start      = 1'b0;
        bus.i_num_rounds = 4'd0;
        bus.i_state      = '0;

        repeat (3) @(negedge clk);
        check_bit("reset_ready", bus.o_ready, 1'b1);
        check_bit("reset_valid", bus.o_valid, 1'b0);
        check_state("reset_state", bus.o_state, zero_st);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("idle_ready", bus.o_ready, 1'b1);
        check_bit("idle_valid", bus.o_valid, 1'b0);
        check_state("idle_state", bus.o_state, zero_st);

        init_st = {64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                   64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                   64'h80400c0600000000};
        do_perm(12, init_st, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) pat[i] = 64'h0123456789ABCDEF ^ 64'(i);
        do_perm(6, pat, 1'b1, 1'b1);
        do_perm(8, pat, 1'b1, 1'b1);

        do_perm(1, zero_st, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        foreach (ROT_A[k]) begin
            if (k < 3) begin
                bus.i_start      = 1'b1;
                bus.i_num_rounds = (k == 0) ? 4'd0 : (k == 1) ? 4'd13 : 4'd15;
                bus.i_state      = rand_state();
                @(negedge clk);
                bus.i_start = 1'b0;
                repeat (2) @(negedge clk);
                check_bit("illegal_n_ready", bus.o_ready, 1'b1);
                check_state("illegal_n_state", bus.o_state, last_res);
            end
        end

        // Reset in the 5th RUN cycle of a p12 discards the partial result.
        bus.i_start      = 1'b1;
        bus.i_num_rounds = 4'd12;
        bus.i_state      = rand_state();
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("midrun_busy", bus.o_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("midrst_ready", bus.o_ready, 1'b1);
        check_bit("midrst_valid", bus.o_valid, 1'b0);
        check_state("midrst_state", bus.o_state, zero_st);

        do_perm(12, init_st, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_perm($urandom_range(1, 12), rand_state(), 1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end
        repeat (3) @(negedge clk);
        check_state("idle_hold", bus.o_state, last_res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/permutation_ctrl.md
Name: permutation_ctrl

Overview:
- Iterative ASCON permutation engine that sits directly upstream of adder_const: registers the 320-bit state, sequences the round index and drives adder_const -> substitution -> linear diffusion once per clock.
- Executes p^N for N = 1..12: p12 for initialisation/finalisation, p6/p8 for data processing.
- Instantiated by the mode FSM (init/AD/text/finalise), which hands it a state and waits for the result.

Parameters:
- NB_ROUNDS_MAX, 12, total number of round constants; the first round index is NB_ROUNDS_MAX - N.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request a permutation; sampled only when o_ready = 1.
- i_num_rounds  input  4  number of rounds N; legal range 1..12.
- i_state  input  t_state_array  state to permute; captured with i_start.
- o_ready  output  1  high in IDLE; block accepts i_start.
- o_valid  output  1  one-cycle pulse; o_state holds the permuted result.
- o_state  output  t_state_array  state register contents; holds the last result until the next accepted start.

Behaviour:
- Reset (synchronous, i_rst = 1 at an edge):
  - FSM -> IDLE; state register -> all-zero; round counter -> 0.
  - o_ready = 1, o_valid = 0, o_state = 0.
  - Reset overrides everything, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start = 1 with 1 <= i_num_rounds <= 12: capture i_state, round_q <= 12 - N, go to RUN.
  - i_start with N = 0 or N > 12: ignored, stay in IDLE, no state change.
- RUN:
  - Each edge: state_q <= round(state_q, round_q); round_q <= round_q + 1.
  - When round_q == 11 is applied, go to DONE.
  - round_q never wraps; it is 4 bits wide and saturates at 11.
- DONE: o_valid = 1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge k -> N round edges (k+1 .. k+N) -> o_valid high in the cycle after edge k+N. Total N+1 cycles from accept to result; N+2 until o_ready returns.
- i_start while in RUN or DONE is ignored; no queueing.
- i_state changes after acceptance have no effect.
- o_state is the register directly, with no combinational path from i_state. It is valid-qualified only by o_valid, and is stable in IDLE.
- Round function: adder_const XORs ROUND_CONSTANTS[round_q] into word 2. The 5-bit S-box is then applied on each of 64 bit-slices, followed by the linear layer with rotations (19,28), (61,39), (1,6), (10,17), (7,41) on words 0..4.

Optional Feature:
- Macro: PERM_UNROLL2_EN.
- Defined:
  - Two cascaded round instances; each RUN edge applies rounds round_q and round_q+1, and round_q advances by 2.
  - RUN lasts ceil(N/2) cycles. If one round remains (odd N), only the first instance's output is registered.
  - DONE is entered once round 11 has been applied.
  - Latency: ceil(N/2)+1 cycles to o_valid.
- Undefined: single instance, one round per cycle as above.
- Port list and handshake are identical in both builds.

Decomposition:
- ascon_pkg holds:
  - t_state_array (existing) and ROUND_CONSTANTS (existing).
  - NB_ROUNDS_MAX.
  - t_perm_fsm enum {IDLE, RUN, DONE}.
- Sub-module: ascon_round (combinational).
  - Ports: i_round[3:0], i_state, o_state.
  - Chains adder_const -> substitution_layer -> diffusion_layer.
  - permutation_ctrl instantiates one copy, or two under PERM_UNROLL2_EN.

Test Plan:
- Reset then idle: i_rst high 3 cycles -> o_ready = 1, o_valid = 0, o_state = 0; after release with i_start = 0 for 10 cycles -> outputs unchanged.
- p12 on the Ascon-128 init state (key = 000102..0F, nonce = 000102..0F), N = 12 -> o_valid exactly 13 cycles after accept; o_state matches the golden C model.
- p6 then p8 back-to-back on state word i = 64'h0123456789ABCDEF ^ i:
  - p6: o_valid at 7 cycles; second start issued the cycle o_ready rises.
  - p8: o_valid at 9 cycles.
  - Both results match the model; i_start pulses during RUN are ignored.
- N = 1 on an all-zero state -> only constant 0x4B is added before S-box/linear; o_valid at 2 cycles; result matches the model. N = 0 and N = 13 -> o_ready stays 1, no o_valid, o_state unchanged.
- Mid-operation reset: i_rst asserted at the 5th RUN cycle of p12 -> next cycle IDLE, o_state = 0, no o_valid. A fresh p12 afterwards gives the correct result.
- PERM_UNROLL2_EN build:
  - p12: o_valid at 7 cycles.
  - p6: o_valid at 4 cycles.
  - N = 5: o_valid at 4 cycles.
  - Outputs bit-identical to the single-round build.
